// File: rtl/branch_target_predictor_if.sv
// Fetch/execute-side bundle of the branch target predictor: IF lookup, EX training,
// table flush and statistics.
interface branch_target_predictor_if #(
  parameter int ADDR_W = 32,
  parameter int STAT_W = 16
);
  logic              lookup_valid;
  logic [ADDR_W-1:0] lookup_pc;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_taken;
  logic              upd_is_jump;
  logic [ADDR_W-1:0] upd_target;
  logic              upd_pred_taken;
  logic [ADDR_W-1:0] upd_pred_target;
  logic              flush_all;
  logic              mispredict;
  logic [STAT_W-1:0] upd_count;
  logic [STAT_W-1:0] mispredict_count;

  modport master (
    output lookup_valid, lookup_pc, upd_valid, upd_pc, upd_taken, upd_is_jump,
           upd_target, upd_pred_taken, upd_pred_target, flush_all,
    input  pred_taken, pred_target, mispredict, upd_count, mispredict_count
  );

  modport slave (
    input  lookup_valid, lookup_pc, upd_valid, upd_pc, upd_taken, upd_is_jump,
           upd_target, upd_pred_taken, upd_pred_target, flush_all,
    output pred_taken, pred_target, mispredict, upd_count, mispredict_count
  );
endinterface

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Zero-latency lookup for IF, training and misprediction flagging from EX.
module branch_target_predictor #(
  parameter int ADDR_W         = 32,
  parameter int ENTRIES        = 16,
  parameter int CTR_W          = 2,
  parameter int STAT_W         = 16,
  parameter int PREDICT_KERNEL = 1
) (
  input logic                      clk,
  input logic                      reset,
  branch_target_predictor_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam logic [CTR_W-1:0]  CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0]  CTR_WEAK = CTR_W'(1) << (CTR_W - 1);
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

  logic              valid_r  [ENTRIES];
  logic [TAG_W-1:0]  tag_r    [ENTRIES];
  logic [ADDR_W-1:0] target_r [ENTRIES];
  logic [CTR_W-1:0]  ctr_r    [ENTRIES];
  logic [STAT_W-1:0] upd_count_r;
  logic [STAT_W-1:0] mispredict_count_r;

  logic [IDX_W-1:0]  lk_idx_s;
  logic [TAG_W-1:0]  lk_tag_s;
  logic              lk_hit_s;
  logic              pred_taken_s;
  logic [ADDR_W-1:0] pred_target_s;
  logic [IDX_W-1:0]  up_idx_s;
  logic [TAG_W-1:0]  up_tag_s;
  logic              up_en_s;
  logic              up_hit_s;
  logic              tbl_we_s;
  logic [CTR_W-1:0]  ctr_nxt_s;
  logic [ADDR_W-1:0] target_nxt_s;
  logic              mispredict_s;

  function automatic logic kernel_ok(input logic [ADDR_W-1:0] pc);
    return (PREDICT_KERNEL != 0) || !pc[ADDR_W-1];
  endfunction

  function automatic logic [CTR_W-1:0] ctr_inc(input logic [CTR_W-1:0] c);
    return (c == CTR_MAX) ? c : c + CTR_W'(1);
  endfunction

  function automatic logic [CTR_W-1:0] ctr_dec(input logic [CTR_W-1:0] c);
    return (c == {CTR_W{1'b0}}) ? c : c - CTR_W'(1);
  endfunction

  // IF lookup: reads the table as it stood before this cycle's update
  always_comb begin
    lk_idx_s     = bus.lookup_pc[IDX_W+1:2];
    lk_tag_s     = bus.lookup_pc[ADDR_W-1:IDX_W+2];
    lk_hit_s     = bus.lookup_valid & valid_r[lk_idx_s] &
                   (tag_r[lk_idx_s] == lk_tag_s) & kernel_ok(bus.lookup_pc);
    pred_taken_s = lk_hit_s & ctr_r[lk_idx_s][CTR_W-1];
    if (pred_taken_s) begin
      pred_target_s = target_r[lk_idx_s];
    end else begin
      pred_target_s = bus.lookup_pc + ADDR_W'(4);
    end
  end

  // EX training: next contents of the entry addressed by upd_pc
  always_comb begin
    up_idx_s     = bus.upd_pc[IDX_W+1:2];
    up_tag_s     = bus.upd_pc[ADDR_W-1:IDX_W+2];
    up_en_s      = bus.upd_valid & kernel_ok(bus.upd_pc);
    up_hit_s     = valid_r[up_idx_s] & (tag_r[up_idx_s] == up_tag_s);
    tbl_we_s     = 1'b0;
    ctr_nxt_s    = ctr_r[up_idx_s];
    target_nxt_s = target_r[up_idx_s];
    mispredict_s = bus.upd_valid &
                   ((bus.upd_taken != bus.upd_pred_taken) |
                    (bus.upd_taken & (bus.upd_target != bus.upd_pred_target)));
    if (up_en_s && up_hit_s) begin
      tbl_we_s = 1'b1;
      if (bus.upd_is_jump) begin
        ctr_nxt_s = CTR_MAX;
      end else if (bus.upd_taken) begin
        ctr_nxt_s = ctr_inc(ctr_r[up_idx_s]);
      end else begin
        ctr_nxt_s = ctr_dec(ctr_r[up_idx_s]);
      end
      if (bus.upd_taken) begin
        target_nxt_s = bus.upd_target;
      end else begin
        target_nxt_s = target_r[up_idx_s];
      end
    end else if (up_en_s && bus.upd_taken) begin
      // Allocation replaces whatever aliased entry lives at this index
      tbl_we_s     = 1'b1;
      ctr_nxt_s    = bus.upd_is_jump ? CTR_MAX : CTR_WEAK;
      target_nxt_s = bus.upd_target;
    end else begin
      tbl_we_s = 1'b0;
    end
  end

  // Table state: reset beats flush, flush beats a same-cycle update
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i]  <= 1'b0;
        tag_r[i]    <= {TAG_W{1'b0}};
        target_r[i] <= {ADDR_W{1'b0}};
        ctr_r[i]    <= {CTR_W{1'b0}};
      end
    end else if (bus.flush_all) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i] <= 1'b0;
      end
    end else if (tbl_we_s) begin
      valid_r[up_idx_s]  <= 1'b1;
      tag_r[up_idx_s]    <= up_tag_s;
      target_r[up_idx_s] <= target_nxt_s;
      ctr_r[up_idx_s]    <= ctr_nxt_s;
    end
  end

  // Saturating statistics; flush and kernel filtering do not suppress counting
  always_ff @(posedge clk) begin
    if (reset) begin
      upd_count_r        <= {STAT_W{1'b0}};
      mispredict_count_r <= {STAT_W{1'b0}};
    end else begin
      if (bus.upd_valid && (upd_count_r != STAT_MAX)) begin
        upd_count_r <= upd_count_r + STAT_W'(1);
      end
      if (mispredict_s && (mispredict_count_r != STAT_MAX)) begin
        mispredict_count_r <= mispredict_count_r + STAT_W'(1);
      end
    end
  end

  assign bus.pred_taken       = pred_taken_s;
  assign bus.pred_target      = pred_target_s;
  assign bus.mispredict       = mispredict_s;
  assign bus.upd_count        = upd_count_r;
  assign bus.mispredict_count = mispredict_count_r;
endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed scoreboard bench: one predictor with kernel prediction enabled and one
// with it disabled, driven by the same stimulus and checked against queued expectations.
module tb_branch_target_predictor;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_target_predictor_if #(.ADDR_W(32), .STAT_W(16)) bus ();
  branch_target_predictor_if #(.ADDR_W(32), .STAT_W(16)) kbus ();

  branch_target_predictor #(.PREDICT_KERNEL(1)) dut (.clk(clk), .reset(reset), .bus(bus));
  branch_target_predictor #(.PREDICT_KERNEL(0)) dut_k (.clk(clk), .reset(reset), .bus(kbus));

  logic        lv, uv, ut, uj, upt, fl;
  logic [31:0] lpc, upc, utgt, uptgt;

  assign bus.lookup_valid     = lv;
  assign bus.lookup_pc        = lpc;
  assign bus.upd_valid        = uv;
  assign bus.upd_pc           = upc;
  assign bus.upd_taken        = ut;
  assign bus.upd_is_jump      = uj;
  assign bus.upd_target       = utgt;
  assign bus.upd_pred_taken   = upt;
  assign bus.upd_pred_target  = uptgt;
  assign bus.flush_all        = fl;
  assign kbus.lookup_valid    = lv;
  assign kbus.lookup_pc       = lpc;
  assign kbus.upd_valid       = uv;
  assign kbus.upd_pc          = upc;
  assign kbus.upd_taken       = ut;
  assign kbus.upd_is_jump     = uj;
  assign kbus.upd_target      = utgt;
  assign kbus.upd_pred_taken  = upt;
  assign kbus.upd_pred_target = uptgt;
  assign kbus.flush_all       = fl;

  typedef struct {
    int          id;
    logic        pt;
    logic [31:0] tgt;
    logic        kpt;
    logic [31:0] ktgt;
    logic        mis;
    int          ucnt;
    int          mcnt;
  } exp_t;

  exp_t exp_q[$];
  logic mon_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  task automatic cmp(input int id, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL vec%0d %s: got %h expected %h", id, nm, act, exp);
    end
  endtask

  // Monitor: compares every presented cycle against the oldest queued expectation
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: output presented with no expectation queued");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        cmp(e.id, "pred_taken",      {31'd0, bus.pred_taken},   {31'd0, e.pt});
        cmp(e.id, "pred_target",     bus.pred_target,           e.tgt);
        cmp(e.id, "mispredict",      {31'd0, bus.mispredict},   {31'd0, e.mis});
        cmp(e.id, "upd_count",       {16'd0, bus.upd_count},    32'(e.ucnt));
        cmp(e.id, "mispr_count",     {16'd0, bus.mispredict_count}, 32'(e.mcnt));
        cmp(e.id, "k_pred_taken",    {31'd0, kbus.pred_taken},  {31'd0, e.kpt});
        cmp(e.id, "k_pred_target",   kbus.pred_target,          e.ktgt);
        cmp(e.id, "k_mispredict",    {31'd0, kbus.mispredict},  {31'd0, e.mis});
        cmp(e.id, "k_upd_count",     {16'd0, kbus.upd_count},   32'(e.ucnt));
        cmp(e.id, "k_mispr_count",   {16'd0, kbus.mispredict_count}, 32'(e.mcnt));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; fl = 1'b0; lv = 1'b0; lpc = 32'h0;
    uv = 1'b0; upc = 32'h0; ut = 1'b0; uj = 1'b0; utgt = 32'h0; upt = 1'b0; uptgt = 32'h0;
  endtask

  task automatic lk(input logic [31:0] pc);
    lv  = 1'b1;
    lpc = pc;
  endtask

  task automatic up(input logic [31:0] pc, input logic t, input logic j, input logic [31:0] tg,
                    input logic p, input logic [31:0] ptg);
    uv = 1'b1; upc = pc; ut = t; uj = j; utgt = tg; upt = p; uptgt = ptg;
  endtask

  task automatic go(input int id, input logic pt, input logic [31:0] tgt, input logic kpt,
                    input logic [31:0] ktgt, input logic mis, input int u, input int m);
    exp_t e;
    e.id = id; e.pt = pt; e.tgt = tgt; e.kpt = kpt; e.ktgt = ktgt;
    e.mis = mis; e.ucnt = u; e.mcnt = m;
    exp_q.push_back(e);
    mon_en = 1'b1;
    tick();
    mon_en = 1'b0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    tick();
    idle();
    lk(32'h8000_0010); go(1, 1'b0, 32'h8000_0014, 1'b0, 32'h8000_0014, 1'b0, 0, 0);
    // Allocation and counter training at 0x40
    idle(); lk(32'h40); up(32'h40, 1'b1, 1'b0, 32'h100, 1'b0, 32'h0);
    go(2, 1'b0, 32'h44, 1'b0, 32'h44, 1'b1, 0, 0);
    idle(); lk(32'h40); go(3, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 1, 1);
    idle(); lk(32'h40); up(32'h40, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100);
    go(4, 1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 1, 1);
    idle(); lk(32'h40); up(32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 32'h44);
    go(5, 1'b0, 32'h44, 1'b0, 32'h44, 1'b0, 2, 2);
    idle(); lk(32'h40); go(6, 1'b0, 32'h44, 1'b0, 32'h44, 1'b0, 3, 2);
    idle(); lk(32'h40); up(32'h40, 1'b1, 1'b0, 32'h100, 1'b0, 32'h0);
    go(7, 1'b0, 32'h44, 1'b0, 32'h44, 1'b1, 3, 2);
    idle(); lk(32'h40); go(8, 1'b0, 32'h44, 1'b0, 32'h44, 1'b0, 4, 3);
    // Aliasing between 0x40 and 0x440
    idle(); lk(32'h440); up(32'h40, 1'b1, 1'b0, 32'h100, 1'b1, 32'h100);
    go(9, 1'b0, 32'h444, 1'b0, 32'h444, 1'b0, 4, 3);
    idle(); lk(32'h440); go(10, 1'b0, 32'h444, 1'b0, 32'h444, 1'b0, 5, 3);
    idle(); lk(32'h40);  go(11, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 5, 3);
    idle(); lk(32'h40); up(32'h440, 1'b1, 1'b0, 32'h200, 1'b0, 32'h0);
    go(12, 1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 5, 3);
    idle(); lk(32'h40);  go(13, 1'b0, 32'h44, 1'b0, 32'h44, 1'b0, 6, 4);
    idle(); lk(32'h440); go(14, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0, 6, 4);
    // Jump allocation saturates the counter
    idle(); lk(32'h80); up(32'h80, 1'b1, 1'b1, 32'h300, 1'b0, 32'h0);
    go(15, 1'b0, 32'h84, 1'b0, 32'h84, 1'b1, 6, 4);
    idle(); lk(32'h80); up(32'h80, 1'b0, 1'b0, 32'h0, 1'b1, 32'h300);
    go(16, 1'b1, 32'h300, 1'b1, 32'h300, 1'b1, 7, 5);
    idle(); lk(32'h80); go(17, 1'b1, 32'h300, 1'b1, 32'h300, 1'b0, 8, 6);
    idle(); lk(32'h80); up(32'h104, 1'b1, 1'b0, 32'h500, 1'b1, 32'h500);
    go(18, 1'b1, 32'h300, 1'b1, 32'h300, 1'b0, 8, 6);
    idle(); lk(32'h104); go(19, 1'b1, 32'h500, 1'b1, 32'h500, 1'b0, 9, 6);
    // Flush drops the concurrent update but still counts it
    idle(); lk(32'h104); up(32'h200, 1'b1, 1'b0, 32'h600, 1'b0, 32'h0); fl = 1'b1;
    go(20, 1'b1, 32'h500, 1'b1, 32'h500, 1'b1, 9, 6);
    idle(); lk(32'h200); go(21, 1'b0, 32'h204, 1'b0, 32'h204, 1'b0, 10, 7);
    idle(); lk(32'h80);  go(22, 1'b0, 32'h84,  1'b0, 32'h84,  1'b0, 10, 7);
    idle(); lk(32'h104); go(23, 1'b0, 32'h108, 1'b0, 32'h108, 1'b0, 10, 7);
    // Kernel PCs: trained only where kernel prediction is enabled
    idle(); lk(32'h8000_0040); up(32'h8000_0040, 1'b1, 1'b0, 32'h700, 1'b0, 32'h0);
    go(24, 1'b0, 32'h8000_0044, 1'b0, 32'h8000_0044, 1'b1, 10, 7);
    idle(); lk(32'h8000_0040); go(25, 1'b1, 32'h700, 1'b0, 32'h8000_0044, 1'b0, 11, 8);
    idle(); lk(32'h8000_0040); up(32'h8000_0040, 1'b1, 1'b0, 32'h700, 1'b1, 32'h700);
    go(26, 1'b1, 32'h700, 1'b0, 32'h8000_0044, 1'b0, 11, 8);
    idle(); lk(32'h8000_0040); up(32'h8000_0040, 1'b1, 1'b0, 32'h700, 1'b1, 32'h700);
    go(27, 1'b1, 32'h700, 1'b0, 32'h8000_0044, 1'b0, 12, 8);
    idle(); lk(32'h8000_0040); up(32'h8000_0040, 1'b0, 1'b0, 32'h0, 1'b1, 32'h700);
    go(28, 1'b1, 32'h700, 1'b0, 32'h8000_0044, 1'b1, 13, 8);
    idle(); lk(32'h8000_0040); go(29, 1'b1, 32'h700, 1'b0, 32'h8000_0044, 1'b0, 14, 9);
    // Reset mid-stream discards the in-flight update
    idle(); lk(32'h8000_0040); up(32'h104, 1'b1, 1'b0, 32'h500, 1'b0, 32'h0); reset = 1'b1;
    go(30, 1'b1, 32'h700, 1'b0, 32'h8000_0044, 1'b1, 14, 9);
    idle(); lk(32'h8000_0040); go(31, 1'b0, 32'h8000_0044, 1'b0, 32'h8000_0044, 1'b0, 0, 0);
    idle(); lk(32'h104); go(32, 1'b0, 32'h108, 1'b0, 32'h108, 1'b0, 0, 0);
    idle(); lk(32'h104); up(32'h104, 1'b1, 1'b0, 32'h500, 1'b1, 32'h504);
    go(33, 1'b0, 32'h108, 1'b0, 32'h108, 1'b1, 0, 0);
    idle(); lk(32'h104); go(34, 1'b1, 32'h500, 1'b1, 32'h500, 1'b0, 1, 1);
    idle(); lpc = 32'h104; go(35, 1'b0, 32'h108, 1'b0, 32'h108, 1'b0, 1, 1);
    idle();
    tick();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d expectations never consumed", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_target_predictor.md
Name: branch_target_predictor

Overview:
- Parametrised fetch-stage branch predictor: direct-mapped branch target buffer (BTB) plus per-entry saturating direction counters.
- Queried combinationally by IF with the current PC; returns a predicted next PC.
- Trained by EX when a branch or jump resolves; flags mispredictions so the hazard logic can flush IF/ID.
- Successor to the fixed PC+4 fetch policy, which always flushes on a taken branch or jump.

Parameters:
- ADDR_W, 32, PC width; bit ADDR_W-1 is the kernel/supervisor bit.
- ENTRIES, 16, BTB entries; power of 2, at least 2. IDX_W = log2(ENTRIES).
- CTR_W, 2, direction counter width; at least 1.
- STAT_W, 16, width of the statistics counters.
- PREDICT_KERNEL, 1, when 0, PCs with bit ADDR_W-1 set are never predicted or trained.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- lookup_valid  in  1  IF lookup enable
- lookup_pc  in  ADDR_W  current IF PC
- pred_taken  out  1  predicted taken
- pred_target  out  ADDR_W  predicted next PC
- upd_valid  in  1  EX resolved a branch or jump this cycle
- upd_pc  in  ADDR_W  PC of the resolved instruction
- upd_taken  in  1  actual outcome
- upd_is_jump  in  1  unconditional jump (j/jal/jr)
- upd_target  in  ADDR_W  actual target
- upd_pred_taken  in  1  prediction carried down the pipe with this instruction
- upd_pred_target  in  ADDR_W  predicted target carried down the pipe
- flush_all  in  1  invalidate the whole table
- mispredict  out  1  combinational misprediction flag for EX
- upd_count  out  STAT_W  number of updates
- mispredict_count  out  STAT_W  number of mispredictions

Behaviour:
- Address split: index = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2]. Bits [1:0] are ignored.
- Entry contents: valid, tag, target (ADDR_W bits), counter (CTR_W bits). Storage is flops or distributed RAM with asynchronous read.
- Lookup (combinational, zero latency):
  - hit = lookup_valid & valid[idx] & (tag match) & kernel_ok.
  - kernel_ok = PREDICT_KERNEL | ~lookup_pc[ADDR_W-1].
  - pred_taken = hit & ctr[CTR_W-1].
  - pred_target = pred_taken ? stored target : lookup_pc+4, modulo 2^ADDR_W.
- mispredict (combinational) = upd_valid & (upd_taken != upd_pred_taken | (upd_taken & upd_target != upd_pred_target)).
- Update, at posedge when upd_valid & kernel_ok(upd_pc):
  - Tag hit: counter saturating +1 if taken, -1 if not taken. If upd_is_jump, counter is set to all-ones. If taken, target is overwritten with upd_target.
  - Miss and taken: allocate. valid=1, tag and target written. Counter = 2^(CTR_W-1) (weakly taken), or all-ones if upd_is_jump. Any aliased entry is replaced.
  - Miss and not taken: no table change.
  - A not-taken update never clears valid.
- Read-during-write: a lookup at the index being updated in the same cycle sees the pre-update contents.
- Statistics:
  - upd_count +1 on every upd_valid, including kernel-filtered updates and updates during flush_all.
  - mispredict_count +1 when mispredict=1.
  - Both saturate at all-ones; no wrap.
- flush_all: at posedge clears every valid bit. Takes priority over a same-cycle table update, which is dropped. Statistics are still counted and are not cleared.
- reset, at posedge with priority over everything:
  - all valid=0, counters=0, targets=0, upd_count=0, mispredict_count=0.
  - Any in-flight update in that cycle is discarded.
  - Outputs after reset: pred_taken=0, pred_target=lookup_pc+4; mispredict follows its inputs.
- No X on outputs after reset. Tags and targets of invalid entries are don't-care internally.

Test Plan:
- Reset, then lookup 0x80000010 -> pred_taken=0, pred_target=0x80000014; both counts 0.
- Update pc=0x40, taken, target 0x100, pred_taken=0 -> mispredict=1 that cycle. Next cycle: lookup 0x40 gives pred_taken=1, target 0x100 (counter=2); mispredict_count=1, upd_count=1.
- Two not-taken updates at 0x40 -> counter goes 2->1->0. Lookup 0x40 then gives pred_taken=0, target 0x44; the entry stays valid (a taken update raises the counter to 1 without reallocating).
- Aliasing (ENTRIES=16): lookup 0x440 misses against the 0x40 entry. A taken update at 0x440 with target 0x200 replaces the entry; afterwards lookup 0x40 misses and 0x440 predicts 0x200.
- Jump update at 0x80 -> counter=3; one not-taken update -> 2, still predicted taken. Same-cycle lookup 0x80 during the first update sees the miss.
- flush_all together with upd_valid -> all entries invalid and the update dropped, but both counts increment.
- With PREDICT_KERNEL=0: a taken update at 0x80000040 is ignored and lookup of that PC misses.
- reset mid-stream with upd_valid=1 -> everything returns to its reset state.
